// File: rtl/fifo_pkg.sv
// fifo_pkg: shared default geometry and threshold constants for FIFO-based blocks
package fifo_pkg;
  localparam int FIFO_DATA_SIZE = 8;
  localparam int FIFO_ADDR_SPACE_EXP = 4;
  localparam int FIFO_ALMOST_FULL_THRESH = 12;
  localparam int FIFO_ALMOST_EMPTY_THRESH = 4;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_SIZE x DEPTH storage, synchronous write, asynchronous read
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int ADDR_SPACE_EXP = FIFO_ADDR_SPACE_EXP
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_SPACE_EXP-1:0] waddr,
  input  logic [ADDR_SPACE_EXP-1:0] raddr,
  input  logic [DATA_SIZE-1:0]      wdata,
  output logic [DATA_SIZE-1:0]      rdata
);
  logic [DATA_SIZE-1:0] mem [2**ADDR_SPACE_EXP];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_status.sv
// fifo_status: show-ahead FIFO with registered level, threshold flags and sticky error flags
module fifo_status
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE = FIFO_DATA_SIZE,
  parameter int ADDR_SPACE_EXP = FIFO_ADDR_SPACE_EXP,
  parameter int ALMOST_FULL_THRESH = FIFO_ALMOST_FULL_THRESH,
  parameter int ALMOST_EMPTY_THRESH = FIFO_ALMOST_EMPTY_THRESH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    write_to_fifo,
  input  logic                    read_from_fifo,
  input  logic [DATA_SIZE-1:0]    write_data_in,
  output logic [DATA_SIZE-1:0]    read_data_out,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic [ADDR_SPACE_EXP:0] level,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int DEPTH = 2**ADDR_SPACE_EXP;
  localparam int LW = ADDR_SPACE_EXP + 1;
  if (ALMOST_EMPTY_THRESH >= ALMOST_FULL_THRESH || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_status: invalid almost thresholds for depth %0d", DEPTH);
  end
  logic [ADDR_SPACE_EXP-1:0] wp, rp;
  logic                      wr_ok, rd_ok, flush;
  logic [LW-1:0]             next_level;
  assign flush = reset || clear;
  assign rd_ok = read_from_fifo && !empty;
  assign wr_ok = write_to_fifo && (!full || rd_ok);
  assign next_level = level + LW'(wr_ok) - LW'(rd_ok);
  fifo_ram #(.DATA_SIZE(DATA_SIZE), .ADDR_SPACE_EXP(ADDR_SPACE_EXP)) u_ram (
    .clk   (clk),
    .we    (wr_ok && !flush),
    .waddr (wp),
    .raddr (rp),
    .wdata (write_data_in),
    .rdata (read_data_out)
  );
  always_ff @(posedge clk) begin
    if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp <= wp + ADDR_SPACE_EXP'(wr_ok);
      rp <= rp + ADDR_SPACE_EXP'(rd_ok);
      level <= next_level;
      empty <= next_level == '0;
      full <= next_level == LW'(DEPTH);
      almost_empty <= next_level <= LW'(ALMOST_EMPTY_THRESH);
      almost_full <= next_level >= LW'(ALMOST_FULL_THRESH);
      overflow <= overflow || (write_to_fifo && !wr_ok);
      underflow <= underflow || (read_from_fifo && !rd_ok);
    end
  end
endmodule

// File: tb/tb_fifo_status.sv
// tb_fifo_status: queue-model checked directed and randomized test of fifo_status
module tb_fifo_status;
  logic       clk = 0, reset = 0, clear = 0, write_to_fifo = 0, read_from_fifo = 0;
  logic [7:0] write_data_in = 0, read_data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] level;
  int         n_cmp = 0, n_err = 0;
  bit         mvalid = 0, m_ov = 0, m_un = 0;
  logic [7:0] q[$];

  fifo_status dut (
    .clk(clk), .reset(reset), .clear(clear),
    .write_to_fifo(write_to_fifo), .read_from_fifo(read_from_fifo),
    .write_data_in(write_data_in), .read_data_out(read_data_out),
    .empty(empty), .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of stored words plus two sticky bits.
  always @(posedge clk) begin
    bit rd, wr;
    if (reset || clear) begin
      q.delete();
      m_ov = 0;
      m_un = 0;
      mvalid = 1;
    end else if (mvalid) begin
      rd = read_from_fifo && q.size() > 0;
      wr = write_to_fifo && (q.size() < 16 || rd);
      if (read_from_fifo && !rd) m_un = 1;
      if (write_to_fifo && !wr) m_ov = 1;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(write_data_in);
    end
  end

  always @(negedge clk) if (mvalid) begin
    check("level", level, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == 16);
    check("almost_empty", almost_empty, q.size() <= 4);
    check("almost_full", almost_full, q.size() >= 12);
    check("overflow", overflow, m_ov);
    check("underflow", underflow, m_un);
    if (q.size() > 0) check("head", read_data_out, q[0]);
  end

  task automatic cyc(bit w, bit r, logic [7:0] d = 0, bit c = 0, bit rs = 0);
    write_to_fifo = w;
    read_from_fifo = r;
    write_data_in = d;
    clear = c;
    reset = rs;
    @(negedge clk);
    write_to_fifo = 0;
    read_from_fifo = 0;
    clear = 0;
    reset = 0;
  endtask

  initial begin
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 8'(k - 1));
      check("fill_level", level, k);
      if (k == 4) check("fill_ae4", almost_empty, 1);
      if (k == 5) check("fill_ae5", almost_empty, 0);
      if (k == 11) check("fill_af11", almost_full, 0);
      if (k == 12) check("fill_af12", almost_full, 1);
    end
    check("fill_full", full, 1);
    check("fill_ov", overflow, 0);
    cyc(1, 0, 8'hFF);
    check("ovf_flag", overflow, 1);
    check("ovf_level", level, 16);
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", read_data_out, i);
      cyc(0, 1);
    end
    check("drain_empty", empty, 1);
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i));
    check("sim_head0", read_data_out, 0);
    cyc(1, 1, 8'hAA);
    check("sim_level", level, 16);
    check("sim_full", full, 1);
    check("sim_head1", read_data_out, 1);
    for (int i = 1; i < 16; i++) begin
      check("sim_order", read_data_out, i);
      cyc(0, 1);
    end
    check("sim_aa", read_data_out, 8'hAA);
    cyc(0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1);
    check("udf_flag", underflow, 1);
    check("udf_level", level, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 1, 8'h5C);
    check("udf_rw_flag", underflow, 1);
    check("udf_rw_level", level, 1);
    check("udf_rw_head", read_data_out, 8'h5C);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      bit r;
      r = level >= 10 ? 1 : level <= 6 ? 0 : 1'($urandom_range(0, 1));
      cyc(1, r, 8'($urandom));
      if (level > 16) check("wrap_bound", level, 16);
    end
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 60) == 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1);
    for (int i = 0; i < 9; i++) cyc(1, 0, 8'(i + 32));
    check("mid_level9", level, 9);
    check("mid_un_set", underflow, 1);
    cyc(1, 0, 8'h77, 1);
    check("mid_level", level, 0);
    check("mid_empty", empty, 1);
    check("mid_ov", overflow, 0);
    check("mid_un", underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
